// File: rtl/idelay_load_seq_pkg.sv
// Shared definitions for the IDELAY load sequencer.
//   - seq_state_e : sequencer state encoding (IDLE, LOAD, SET, SETTLE)
//   - dly_field_t : 8-bit delay tap value, {coarse[7:3], fine[2:0]}
//   - sat_inc     : saturating increment for the 8-bit settle counter
package idelay_load_seq_pkg;

  localparam int DLY_W    = 8;
  localparam int COARSE_W = 5;
  localparam int FINE_W   = 3;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SET    = 2'd2,
    ST_SETTLE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } dly_field_t;

  // The settle counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/idelay_lane_regs.sv
// Per-lane delay register pairs with readback.
//   pending[i]   : written when a valid load strobe targets lane i
//   committed[i] : copied from pending[i] for every lane on i_commit
// Ports:
//   clk, rst_n      clock and async active-low reset
//   i_wr_en         write i_wr_data into pending[i_wr_lane]
//   i_wr_lane       target lane (caller guarantees it is in range)
//   i_wr_data       8-bit delay value
//   i_commit        copy all pending values into committed
//   i_rd_lane       readback index
//   o_rd_delay      committed[i_rd_lane], or 8'h00 for an out-of-range index
module idelay_lane_regs import idelay_load_seq_pkg::*; #(
  parameter int         NUM_LANES   = 8,
  parameter int         LANE_W      = 3,
  parameter logic [7:0] DELAY_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [LANE_W-1:0] i_wr_lane,
  input  logic [DLY_W-1:0]  i_wr_data,
  input  logic              i_commit,
  input  logic [LANE_W-1:0] i_rd_lane,
  output logic [DLY_W-1:0]  o_rd_delay
);

  logic [DLY_W-1:0] r_pending   [NUM_LANES];
  logic [DLY_W-1:0] r_committed [NUM_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_pending[i]   <= DELAY_VALUE;
        r_committed[i] <= DELAY_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i_wr_en && (i_wr_lane == LANE_W'(i))) begin
          r_pending[i] <= i_wr_data;
        end
        if (i_commit) begin
          r_committed[i] <= r_pending[i];
        end
      end
    end
  end

  // Compare-based mux so indices beyond NUM_LANES fall through to zero.
  always_comb begin
    o_rd_delay = 8'h00;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_rd_lane == LANE_W'(i)) begin
        o_rd_delay = r_committed[i];
      end
    end
  end

endmodule

// File: rtl/idelay_load_seq.sv
// IDELAY load sequencer: loads per-lane delay taps over a shared bus, then
// issues a common set strobe and waits for the delay lanes to settle.
// Ports:
//   clk, rst_n            clock; async active-low reset, deassertion synchronised
//   dly_rdy               delay control calibrated/ready
//   cmd_valid/cmd_ready   command handshake
//   cmd_ld, cmd_apply     load cmd_delay into cmd_lane / finish with set+settle
//   cmd_lane, cmd_delay   target lane, {coarse[7:3], fine[2:0]}
//   dly_ld                one-hot per-lane load strobe (one cycle)
//   dly_set               common set strobe (one cycle)
//   dly_out               shared delay bus, holds last loaded value
//   busy, done, err       state != IDLE, end-of-settle pulse, bad-lane pulse
//   rd_lane, rd_delay     combinational readback of committed values
//   dbg_state             current sequencer state
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on dly_rdy and state, never on
// cmd_valid. The command fields are only looked at in the transfer cycle.
module idelay_load_seq import idelay_load_seq_pkg::*; #(
  parameter int         NUM_LANES     = 8,
  parameter int         LANE_W        = 3,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] DELAY_VALUE   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dly_rdy,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_ld,
  input  logic                 cmd_apply,
  input  logic [LANE_W-1:0]    cmd_lane,
  input  logic [DLY_W-1:0]     cmd_delay,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic                 dly_set,
  output logic [DLY_W-1:0]     dly_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [LANE_W-1:0]    rd_lane,
  output logic [DLY_W-1:0]     rd_delay,
  output seq_state_e           dbg_state
);

  // Reset assertion is immediate; release ripples through two flops so
  // every register leaves reset on the same clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  seq_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_LANES-1:0] r_dly_ld, w_ld_nxt;
  logic                 r_dly_set, r_done, r_err;
  dly_field_t           r_dly_out;
  logic                 w_accept, w_lane_ok, w_ld_valid, w_err_nxt, w_done_nxt;

  assign cmd_ready  = dly_rdy && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_lane_ok  = (int'(cmd_lane) < NUM_LANES);
  assign w_ld_valid = w_accept && cmd_ld && w_lane_ok;
  assign w_err_nxt  = w_accept && cmd_ld && !w_lane_ok;

  always_comb begin
    w_ld_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_ld_nxt[i] = w_ld_valid && (cmd_lane == LANE_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = cmd_apply ? ST_SET : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept)      w_state_nxt = cmd_apply ? ST_SET : ST_LOAD;
        else if (dly_rdy)  w_state_nxt = ST_IDLE;
        // dly_rdy low: hold LOAD, only cmd_ready drops
      end
      ST_SET: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The first SETTLE cycle carries dly_set and is not counted.
        if (r_dly_set || !dly_rdy) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= CNT_W'(SETTLE_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // dly_set follows the SET state by one cycle so it lands after any load
  // strobe issued for the applying command.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dly_ld  <= '0;
      r_dly_set <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_dly_out <= dly_field_t'(DELAY_VALUE);
    end else begin
      r_dly_ld  <= w_ld_nxt;
      r_dly_set <= (r_state == ST_SET);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      if (w_ld_valid) r_dly_out <= dly_field_t'(cmd_delay);
    end
  end

  idelay_lane_regs #(
    .NUM_LANES   (NUM_LANES),
    .LANE_W      (LANE_W),
    .DELAY_VALUE (DELAY_VALUE)
  ) u_lane_regs (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_wr_en    (w_ld_valid),
    .i_wr_lane  (cmd_lane),
    .i_wr_data  (cmd_delay),
    .i_commit   (r_dly_set),
    .i_rd_lane  (rd_lane),
    .o_rd_delay (rd_delay)
  );

  assign dly_ld    = r_dly_ld;
  assign dly_set   = r_dly_set;
  assign dly_out   = r_dly_out;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_idelay_load_seq.sv
module tb_idelay_load_seq;
  import idelay_load_seq_pkg::*;

  localparam int         NL = 8;
  localparam int         LW = 4;
  localparam int         SC = 16;
  localparam logic [7:0] DV = 8'h2B;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dly_rdy = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ld = 1'b0;
  logic          cmd_apply = 1'b0;
  logic [LW-1:0] cmd_lane = '0;
  logic [7:0]    cmd_delay = '0;
  logic [LW-1:0] rd_lane = '0;
  logic          cmd_ready, dly_set, busy, done, err;
  logic [NL-1:0] dly_ld;
  logic [7:0]    dly_out, rd_delay;
  seq_state_e    dbg_state;

  always #5 clk = ~clk;

  idelay_load_seq #(
    .NUM_LANES(NL), .LANE_W(LW), .SETTLE_CYCLES(SC), .DELAY_VALUE(DV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dly_rdy(dly_rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_apply(cmd_apply), .cmd_lane(cmd_lane), .cmd_delay(cmd_delay),
    .dly_ld(dly_ld), .dly_set(dly_set), .dly_out(dly_out), .busy(busy),
    .done(done), .err(err), .rd_lane(rd_lane), .rd_delay(rd_delay),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic ld, input logic ap,
                      input logic [LW-1:0] lane, input logic [7:0] dly);
    cmd_valid = v;
    cmd_ld    = ld;
    cmd_apply = ap;
    cmd_lane  = lane;
    cmd_delay = dly;
  endtask

  task automatic idle_cmd();
    send(1'b0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v, ld, ap;
    logic [LW-1:0] lane;
    logic [7:0]    dly;
    logic [LW-1:0] rl;
    logic [7:0]    e_ld, e_out;
    logic          e_set, e_err, e_ready, e_busy;
    logic [7:0]    e_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic ld, input logic ap,
                              input logic [LW-1:0] lane, input logic [7:0] dly,
                              input logic [LW-1:0] rl, input logic [7:0] e_ld,
                              input logic [7:0] e_out, input logic e_set,
                              input logic e_err, input logic e_ready,
                              input logic e_busy, input logic [7:0] e_rd);
    vec_t r;
    r.v = v; r.ld = ld; r.ap = ap; r.lane = lane; r.dly = dly; r.rl = rl;
    r.e_ld = e_ld; r.e_out = e_out; r.e_set = e_set; r.e_err = e_err;
    r.e_ready = e_ready; r.e_busy = e_busy; r.e_rd = e_rd;
    return r;
  endfunction

  vec_t tbl [11];

  initial begin
    logic got;

    // ---- reset state ----
    dly_rdy = 1'b1;
    #12;
    chk8("rst_ld", dly_ld, 8'h00);
    chk1("rst_set", dly_set, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_out", dly_out, DV);
    chk1("rst_ready_hi", cmd_ready, 1'b1);
    chk8("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    for (int i = 0; i < NL; i++) begin
      rd_lane = LW'(i);
      #1;
      chk8($sformatf("rst_rd[%0d]", i), rd_delay, DV);
    end
    rd_lane = 4'd9;
    #1;
    chk8("rst_rd[9]", rd_delay, 8'h00);
    dly_rdy = 1'b0;
    #1;
    chk1("rst_ready_lo", cmd_ready, 1'b0);
    dly_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // ---- no-op accept, back-to-back loads 0,1,2, apply on the last ----
    //             v     ld    ap    lane  dly    rl     e_ld   e_out  set   err   rdy   busy  e_rd
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 8'h2B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2B);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 4'd0, 8'h11, 4'd0, 8'h00, 8'h2B, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 4'd1, 8'h22, 4'd0, 8'h01, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 4'd2, 8'h33, 4'd1, 8'h02, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd2, 8'h04, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2B);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd2, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].v, tbl[i].ld, tbl[i].ap, tbl[i].lane, tbl[i].dly);
      rd_lane = tbl[i].rl;
      #1;
      chk8($sformatf("tbl[%0d].ld", i), dly_ld, tbl[i].e_ld);
      chk8($sformatf("tbl[%0d].out", i), dly_out, tbl[i].e_out);
      chk1($sformatf("tbl[%0d].set", i), dly_set, tbl[i].e_set);
      chk1($sformatf("tbl[%0d].err", i), err, tbl[i].e_err);
      chk1($sformatf("tbl[%0d].ready", i), cmd_ready, tbl[i].e_ready);
      chk1($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
      chk8($sformatf("tbl[%0d].rd", i), rd_delay, tbl[i].e_rd);
      chk1($sformatf("tbl[%0d].done", i), done, 1'b0);
      tick();
    end
    // apply accepted at index 3, so done lands at index 3+19
    for (int k = 11; k <= 23; k++) begin
      chk1($sformatf("a_done@%0d", k), done, k == 22);
      chk1($sformatf("a_busy@%0d", k), busy, k < 22);
      tick();
    end

    // ---- single load+apply lane 3 = 5D ----
    send(1'b1, 1'b1, 1'b1, 4'd3, 8'h5D);
    rd_lane = 4'd3;
    #1;
    chk1("b_ready", cmd_ready, 1'b1);
    tick();
    idle_cmd();
    for (int k = 1; k <= 21; k++) begin
      chk8($sformatf("b_ld@T+%0d", k), dly_ld, (k == 1) ? 8'h08 : 8'h00);
      chk8($sformatf("b_out@T+%0d", k), dly_out, 8'h5D);
      chk1($sformatf("b_set@T+%0d", k), dly_set, k == 2);
      chk1($sformatf("b_done@T+%0d", k), done, k == 19);
      chk1($sformatf("b_busy@T+%0d", k), busy, k < 19);
      chk8($sformatf("b_rd3@T+%0d", k), rd_delay, (k >= 3) ? 8'h5D : 8'h2B);
      tick();
    end

    // ---- out-of-range lane 9 ----
    send(1'b1, 1'b1, 1'b0, 4'd9, 8'hEE);
    tick();
    idle_cmd();
    chk1("c_err_pulse", err, 1'b1);
    chk8("c_ld_none", dly_ld, 8'h00);
    chk8("c_out_hold", dly_out, 8'h5D);
    chk8("c_state_load", 8'(dbg_state), 8'(ST_LOAD));
    tick();
    chk1("c_err_clear", err, 1'b0);
    chk8("c_state_idle", 8'(dbg_state), 8'(ST_IDLE));
    send(1'b1, 1'b1, 1'b1, 4'd9, 8'hEE);
    tick();
    idle_cmd();
    chk1("c2_err_pulse", err, 1'b1);
    chk8("c2_ld_none", dly_ld, 8'h00);
    tick();
    chk1("c2_set", dly_set, 1'b1);
    chk1("c2_err_clear", err, 1'b0);
    tick();
    rd_lane = 4'd3;
    #1;
    chk8("c2_rd3", rd_delay, 8'h5D);
    rd_lane = 4'd0;
    #1;
    chk8("c2_rd0", rd_delay, 8'h11);
    rd_lane = 4'd9;
    #1;
    chk8("c2_rd9", rd_delay, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!got) begin
        if (done) got = 1'b1;
        else tick();
      end
    end
    chk1("c2_done_seen", got, 1'b1);
    tick();

    // ---- dly_rdy drop while in LOAD ----
    send(1'b1, 1'b1, 1'b0, 4'd4, 8'h44);
    tick();
    idle_cmd();
    dly_rdy = 1'b0;
    #1;
    chk1("d_ready_lo", cmd_ready, 1'b0);
    chk8("d_ld4", dly_ld, 8'h10);
    tick();
    chk8("d_state_load", 8'(dbg_state), 8'(ST_LOAD));
    chk1("d_busy", busy, 1'b1);
    dly_rdy = 1'b1;
    #1;
    chk1("d_ready_hi", cmd_ready, 1'b1);
    tick();
    chk8("d_state_idle", 8'(dbg_state), 8'(ST_IDLE));
    chk1("d_busy_clr", busy, 1'b0);

    // ---- dly_rdy low for 5 cycles mid-SETTLE after 4 counted cycles ----
    send(1'b1, 1'b1, 1'b1, 4'd5, 8'h77);
    tick();
    idle_cmd();
    for (int k = 1; k <= 30; k++) begin
      dly_rdy = !(k >= 7 && k <= 11);
      #1;
      if (k >= 7 && k <= 11) chk1($sformatf("e_ready@T+%0d", k), cmd_ready, 1'b0);
      chk1($sformatf("e_done@T+%0d", k), done, k == 28);
      tick();
    end
    dly_rdy = 1'b1;
    chk1("e_busy_clr", busy, 1'b0);
    rd_lane = 4'd5;
    #1;
    chk8("e_rd5", rd_delay, 8'h77);
    rd_lane = 4'd4;
    #1;
    chk8("e_rd4", rd_delay, 8'h44);
    tick();

    // ---- reset at settle count 7 ----
    send(1'b1, 1'b1, 1'b1, 4'd6, 8'h99);
    tick();
    idle_cmd();
    for (int k = 1; k <= 9; k++) tick();
    rst_n = 1'b0;
    #1;
    chk8("f_state", 8'(dbg_state), 8'(ST_IDLE));
    chk1("f_busy", busy, 1'b0);
    chk1("f_done", done, 1'b0);
    chk1("f_set", dly_set, 1'b0);
    chk8("f_out", dly_out, DV);
    rd_lane = 4'd3;
    #1;
    chk8("f_rd3", rd_delay, DV);
    rd_lane = 4'd6;
    #1;
    chk8("f_rd6", rd_delay, DV);
    tick();
    tick();
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk1("f_no_done", got, 1'b0);
    chk8("f_state_after", 8'(dbg_state), 8'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idelay_load_seq.md
IDELAY_LOAD_SEQ -- requirements
Module: idelay_load_seq

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8: number of fine-pipe delay lanes driven.
REQ-002 SHALL have parameter LANE_W, default 3: lane index width, with 2**LANE_W >= NUM_LANES.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: wait after the set pulse, range 1..255.
REQ-004 SHALL have parameter DELAY_VALUE, default 0: 8-bit reset/initial delay of every lane.
REQ-005 SHALL have ports:
  clk  in  1  single clock for all logic and delay lanes
  rst_n  in  1  asynchronous, active-low reset
  dly_rdy  in  1  delay-control calibrated/ready flag
  cmd_valid  in  1  command present
  cmd_ready  out  1  command accepted when valid && ready
  cmd_ld  in  1  command loads cmd_delay into lane cmd_lane
  cmd_apply  in  1  command ends with a common set and settle
  cmd_lane  in  LANE_W  target lane
  cmd_delay  in  8  {coarse[7:3], fine[2:0]}
  dly_ld  out  NUM_LANES  one-hot per-lane load strobe
  dly_set  out  1  common set strobe to all lanes
  dly_out  out  8  shared delay bus
  busy  out  1  state != IDLE
  done  out  1  one-cycle pulse at end of settle
  err  out  1  one-cycle pulse for an out-of-range lane
  rd_lane  in  LANE_W  readback index
  rd_delay  out  8  committed delay of rd_lane, combinational

Function
REQ-006 SHALL implement states IDLE, LOAD, SET, SETTLE.
REQ-007 SHALL drive cmd_ready = dly_rdy && (state is IDLE or LOAD).
REQ-008 On accept at cycle T with cmd_ld=1 and a valid lane: SHALL drive dly_ld[cmd_lane]=1 and dly_out=cmd_delay at T+1 only, and SHALL write pending[cmd_lane].
REQ-009 Accept with cmd_ld=1 and cmd_lane >= NUM_LANES: SHALL keep dly_ld at 0, pulse err at T+1, leave pending unchanged, and still honour cmd_apply.
REQ-010 dly_out SHALL hold its last value when no load strobe is active.
REQ-011 Accept without cmd_apply: SHALL go to LOAD, which supports back-to-back accepts on consecutive cycles; with no accept in LOAD, SHALL return to IDLE next cycle.
REQ-012 Accept with cmd_apply: SHALL go to SET, with dly_set=1 for exactly one cycle at T+2 (after any ld at T+1).
REQ-013 In the dly_set cycle, SHALL copy pending to committed for every lane.
REQ-014 SET SHALL always go to SETTLE; SETTLE SHALL count SETTLE_CYCLES cycles with dly_rdy=1 (T+3 onward, no drop), then pulse done and enter IDLE in the same cycle.
REQ-015 If dly_rdy drops during SETTLE: the counter SHALL clear, hold while dly_rdy=0, and restart from 0 when dly_rdy returns.
REQ-016 A dly_rdy drop during LOAD SHALL only deassert cmd_ready; the state SHALL stay LOAD.
REQ-017 Accept with cmd_ld=0 and cmd_apply=0 SHALL be a no-op with no strobes.
REQ-018 rd_delay SHALL equal committed[rd_lane], or 8'h00 when rd_lane >= NUM_LANES.
REQ-019 The settle counter SHALL be 8 bits and SHALL saturate, never wrap.

Reset
REQ-020 rst_n low SHALL asynchronously force state IDLE and clear counter, dly_ld, dly_set, done and err.
REQ-021 rst_n low SHALL set dly_out, pending[] and committed[] to DELAY_VALUE.
REQ-022 Reset mid-SETTLE or mid-LOAD SHALL abort with no done pulse.
REQ-023 Deassertion of rst_n SHALL be taken synchronously to clk.

Structure
REQ-024 State encoding and the 8-bit delay field split (coarse 5 bits, fine 3 bits) SHALL live in the shared memory-interface package.
REQ-025 Natural sub-module: idelay_lane_regs, holding the pending/committed register pair per lane plus readback mux.

Verification
REQ-026 Reset with DELAY_VALUE=8'h2B -> all rd_delay=8'h2B, all strobes 0, cmd_ready = dly_rdy.
REQ-027 Accept {ld, lane 3, 8'h5D, apply} at T -> dly_ld=8'b0000_1000 and dly_out=8'h5D at T+1; dly_set at T+2; done at T+19 (SETTLE_CYCLES=16); rd_delay(3)=8'h5D from T+3.
REQ-028 Back-to-back loads lanes 0,1,2 on consecutive cycles, apply on the last -> three single-cycle one-hot ld pulses, one dly_set, all three lanes committed together.
REQ-029 Load lane 9 with NUM_LANES=8 -> err pulse, no dly_ld, committed values unchanged.
REQ-030 dly_rdy low for 5 cycles mid-SETTLE -> done delayed by 5 cycles plus the cycles already counted; cmd_ready low throughout.
REQ-031 rst_n asserted at SETTLE count 7 -> no done, state IDLE, committed back to DELAY_VALUE.
